// File: rtl/xts_pkg.sv
// xts_pkg
// Shared definitions for the XTS whitening stage: block width, the GF(2^128)
// reduction constant, the stage FSM encoding and the multiply-by-alpha helper.
// The helper is plain combinational logic, so software models can call it too.
package xts_pkg;

    localparam int BLOCK_W = 128;

    // Low-order terms of x^128 + x^7 + x^2 + x + 1 folded back in after a carry
    localparam logic [BLOCK_W-1:0] GF_POLY = 128'h87;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } xts_state_e;

    // Multiply by alpha (x) in GF(2^128) using the XTS little-endian integer
    // form: shift left one bit and reduce when bit 127 falls off the top.
    function automatic logic [BLOCK_W-1:0] gf_mul_alpha(input logic [BLOCK_W-1:0] t);
        return {t[BLOCK_W-2:0], 1'b0} ^ (t[BLOCK_W-1] ? GF_POLY : '0);
    endfunction

endpackage

// File: rtl/xts_tweak_fifo.sv
// xts_tweak_fifo
// Register-based FIFO that holds the per-block tweaks while their blocks are
// inside the cipher core. Push and pop can happen together in one cycle.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_push, i_pushData  write a tweak (ignored when full)
//   i_pop               drop the head entry (ignored when empty)
//   o_headData          oldest stored tweak
//   o_full, o_empty     occupancy flags
module xts_tweak_fifo
    import xts_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [BLOCK_W-1:0] i_pushData,
    input  logic               i_pop,
    output logic [BLOCK_W-1:0] o_headData,
    output logic               o_full,
    output logic               o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [BLOCK_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;

    logic w_doPush;
    logic w_doPop;

    assign w_doPush   = i_push && !o_full;
    assign w_doPop    = i_pop && !o_empty;
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_headData = r_mem[r_rdPtr];

    // Storage array needs no reset: entries are only read once counted valid.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
    // push and pop leaves the count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
        end
    end

endmodule

// File: rtl/xts_tweak_stage.sv
// xts_tweak_stage
// XTS whitening around a block cipher core. A sector tweak T0 is loaded in
// IDLE; each accepted input block is XORed with the running tweak T_j before
// the core, T_j is queued, and the core result is XORed with the same T_j on
// the way out. Encrypt and decrypt whiten identically.
// Ports:
//   i_clk, i_rst                          clock, synchronous active-high reset
//   i_tweak, i_tweak_valid, o_tweak_ready sector tweak load (IDLE only)
//   i_data, i_data_valid, o_data_ready    input block handshake
//   o_cipher_data, o_cipher_valid         pre-whitened block to the core
//   i_cipher_data, i_cipher_valid         core result (no backpressure)
//   o_data, o_data_valid                  post-whitened result
//   o_err                                 sticky: core result with no tweak queued
module xts_tweak_stage
    import xts_pkg::*;
#(
    parameter int DEPTH             = 4,
    parameter int BLOCKS_PER_SECTOR = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [BLOCK_W-1:0] i_tweak,
    input  logic               i_tweak_valid,
    output logic               o_tweak_ready,
    input  logic [BLOCK_W-1:0] i_data,
    input  logic               i_data_valid,
    output logic               o_data_ready,
    output logic [BLOCK_W-1:0] o_cipher_data,
    output logic               o_cipher_valid,
    input  logic [BLOCK_W-1:0] i_cipher_data,
    input  logic               i_cipher_valid,
    output logic [BLOCK_W-1:0] o_data,
    output logic               o_data_valid,
    output logic               o_err
);

    localparam int                CNT_W = (BLOCKS_PER_SECTOR > 1) ? $clog2(BLOCKS_PER_SECTOR) : 1;
    localparam logic [CNT_W-1:0]  LAST_BLOCK = CNT_W'(BLOCKS_PER_SECTOR - 1);

    xts_state_e         r_state;
    logic [BLOCK_W-1:0] r_tweak;
    logic [CNT_W-1:0]   r_blockCount;
    logic [BLOCK_W-1:0] r_cipherData;
    logic               r_cipherValid;
    logic [BLOCK_W-1:0] r_outData;
    logic               r_outValid;
    logic               r_err;

    logic               w_inFire;
    logic               w_outFire;
    logic               w_fifoFull;
    logic               w_fifoEmpty;
    logic [BLOCK_W-1:0] w_fifoHead;

    // Ready depends only on registered state and FIFO occupancy, never on valid.
    assign o_tweak_ready = (r_state == ST_IDLE);
    assign o_data_ready  = (r_state == ST_ACTIVE) && !w_fifoFull;
    assign w_inFire      = i_data_valid && o_data_ready;
    assign w_outFire     = i_cipher_valid && !w_fifoEmpty;

    assign o_cipher_data  = r_cipherData;
    assign o_cipher_valid = r_cipherValid;
    assign o_data         = r_outData;
    assign o_data_valid   = r_outValid;
    assign o_err          = r_err;

    xts_tweak_fifo #(
        .DEPTH (DEPTH)
    ) u_tweakFifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_inFire),
        .i_pushData (r_tweak),
        .i_pop      (w_outFire),
        .o_headData (w_fifoHead),
        .o_full     (w_fifoFull),
        .o_empty    (w_fifoEmpty)
    );

    // Sector FSM: IDLE waits for a tweak, ACTIVE whitens blocks and advances
    // the tweak by alpha per block until the last block of the sector.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_tweak       <= '0;
            r_blockCount  <= '0;
            r_cipherData  <= '0;
            r_cipherValid <= 1'b0;
        end else begin
            r_cipherValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_tweak_valid) begin
                        r_tweak      <= i_tweak;
                        r_blockCount <= '0;
                        r_state      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_inFire) begin
                        r_cipherData  <= i_data ^ r_tweak;
                        r_cipherValid <= 1'b1;
                        r_tweak       <= gf_mul_alpha(r_tweak);
                        r_blockCount  <= r_blockCount + CNT_W'(1);
                        if (r_blockCount == LAST_BLOCK) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Result path runs independently of the FSM so queued tweaks keep
    // draining after the sector ends. A result with no queued tweak is
    // dropped and latches the error flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            if (w_outFire) begin
                r_outData  <= i_cipher_data ^ w_fifoHead;
                r_outValid <= 1'b1;
            end
            if (i_cipher_valid && w_fifoEmpty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xts_tweak_stage.sv
// tb_xts_tweak_stage
// Drives the whitening stage with table vectors and random sectors through a
// modelled identity core of configurable latency, comparing every cycle
// against a transaction-level model built on a tweak queue.
module tb_xts_tweak_stage;
    import xts_pkg::*;

    localparam int DEPTH = 4;
    localparam int BPS   = 32;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [127:0] i_tweak = '0;
    logic         i_tweak_valid = 1'b0;
    logic         o_tweak_ready;
    logic [127:0] i_data = '0;
    logic         i_data_valid = 1'b0;
    logic         o_data_ready;
    logic [127:0] o_cipher_data;
    logic         o_cipher_valid;
    logic [127:0] i_cipher_data = '0;
    logic         i_cipher_valid = 1'b0;
    logic [127:0] o_data;
    logic         o_data_valid;
    logic         o_err;

    xts_tweak_stage #(
        .DEPTH             (DEPTH),
        .BLOCKS_PER_SECTOR (BPS)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_tweak        (i_tweak),
        .i_tweak_valid  (i_tweak_valid),
        .o_tweak_ready  (o_tweak_ready),
        .i_data         (i_data),
        .i_data_valid   (i_data_valid),
        .o_data_ready   (o_data_ready),
        .o_cipher_data  (o_cipher_data),
        .o_cipher_valid (o_cipher_valid),
        .i_cipher_data  (i_cipher_data),
        .i_cipher_valid (i_cipher_valid),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .o_err          (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Modelled core: identity with fixed latency, entries carry their due cycle
    typedef struct {
        logic [127:0] data;
        int           due;
    } core_item_t;

    typedef struct {
        logic [127:0] t0;
        int           idx;
        logic [127:0] din;
        logic [127:0] expCipher;
    } vec_t;

    core_item_t   corePipe[$];
    int           coreLat = 3;
    bit           injectCipher = 1'b0;
    logic [127:0] injectData = '0;

    // Reference model state: sector activity, running tweak, queued tweaks
    bit           mActive;
    logic [127:0] mT;
    int           mCnt;
    logic [127:0] mQ[$];
    bit           mErr;
    bit           mCV;
    logic [127:0] mCD;
    bit           mDV;
    logic [127:0] mD;

    logic [127:0] pendQ[$];
    logic [127:0] sentQ[$];
    logic [127:0] outLog[$];

    int passCount  = 0;
    int checkCount = 0;
    int cycle      = 0;
    bit lastHs;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end else begin
            passCount++;
        end
    endtask

    task automatic failBound(input string name);
        checkCount++;
        $display("[TB] FAIL %s: bound expired at cycle %0d", name, cycle);
    endtask

    // One clock cycle: drive inputs, check ready, advance the model, clock,
    // then compare every registered output with the model.
    task automatic applyStimulus(input bit dv, input logic [127:0] din,
                                 input bit tv, input logic [127:0] tin);
        bit           civ;
        logic [127:0] cd;
        bit           expReady;
        bit           hs;
        i_data_valid  = dv;
        i_data        = din;
        i_tweak_valid = tv;
        i_tweak       = tin;
        civ = 1'b0;
        cd  = '0;
        if (injectCipher) begin
            civ = 1'b1;
            cd  = injectData;
            injectCipher = 1'b0;
        end else if (corePipe.size() > 0 && corePipe[0].due <= cycle) begin
            civ = 1'b1;
            cd  = corePipe[0].data;
            void'(corePipe.pop_front());
        end
        i_cipher_valid = civ;
        i_cipher_data  = cd;
        #1;
        expReady = mActive && (mQ.size() < DEPTH);
        checkOutput("o_data_ready", 128'(o_data_ready), 128'(expReady));
        checkOutput("o_tweak_ready", 128'(o_tweak_ready), 128'(!mActive));

        mDV = 1'b0;
        if (civ) begin
            if (mQ.size() > 0) begin
                mD  = cd ^ mQ.pop_front();
                mDV = 1'b1;
            end else begin
                mErr = 1'b1;
            end
        end
        hs  = dv && expReady;
        mCV = 1'b0;
        if (hs) begin
            mCD = din ^ mT;
            mCV = 1'b1;
            mQ.push_back(mT);
            mT = gf_mul_alpha(mT);
            if (mCnt == BPS - 1) mActive = 1'b0;
            mCnt++;
        end else if (!mActive && tv) begin
            mT      = tin;
            mCnt    = 0;
            mActive = 1'b1;
        end
        lastHs = hs;

        @(posedge i_clk);
        #1;
        cycle++;
        checkOutput("o_cipher_valid", 128'(o_cipher_valid), 128'(mCV));
        checkOutput("o_cipher_data", o_cipher_data, mCD);
        checkOutput("o_data_valid", 128'(o_data_valid), 128'(mDV));
        checkOutput("o_data", o_data, mD);
        checkOutput("o_err", 128'(o_err), 128'(mErr));
        if (o_cipher_valid) corePipe.push_back('{o_cipher_data, cycle + coreLat - 1});
        if (o_data_valid) outLog.push_back(o_data);
    endtask

    // Stage and core are reset together; check every reset value.
    task automatic doReset();
        i_rst          = 1'b1;
        i_data_valid   = 1'b0;
        i_tweak_valid  = 1'b0;
        i_cipher_valid = 1'b0;
        @(posedge i_clk);
        #1;
        cycle++;
        i_rst = 1'b0;
        corePipe.delete();
        mQ.delete();
        sentQ.delete();
        outLog.delete();
        mActive = 1'b0; mT = '0; mCnt = 0; mErr = 1'b0;
        mCV = 1'b0; mCD = '0; mDV = 1'b0; mD = '0;
        checkOutput("reset o_tweak_ready", 128'(o_tweak_ready), 128'd1);
        checkOutput("reset o_data_ready", 128'(o_data_ready), 128'd0);
        checkOutput("reset o_cipher_valid", 128'(o_cipher_valid), 128'd0);
        checkOutput("reset o_data_valid", 128'(o_data_valid), 128'd0);
        checkOutput("reset o_err", 128'(o_err), 128'd0);
        checkOutput("reset o_cipher_data", o_cipher_data, 128'd0);
        checkOutput("reset o_data", o_data, 128'd0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0);
    endtask

    task automatic loadTweak(input logic [127:0] t);
        applyStimulus(1'b0, '0, 1'b1, t);
    endtask

    task automatic feedAll();
        int budget = 2000;
        while (pendQ.size() > 0 && budget > 0) begin
            applyStimulus(1'b1, pendQ[0], 1'b0, '0);
            if (lastHs) sentQ.push_back(pendQ.pop_front());
            budget--;
        end
        if (pendQ.size() > 0) begin
            failBound("feed");
            pendQ.delete();
        end
    endtask

    task automatic drain();
        int budget = 200;
        while (corePipe.size() > 0 && budget > 0) begin
            applyStimulus(1'b0, '0, 1'b0, '0);
            budget--;
        end
        if (corePipe.size() > 0) failBound("drain");
        idleCycles(1);
    endtask

    // Identity core means each whitened-out block must equal what went in.
    task automatic checkLoopback(input string name);
        checkOutput({name, " count"}, 128'(outLog.size()), 128'(sentQ.size()));
        for (int i = 0; i < sentQ.size() && i < outLog.size(); i++) begin
            checkOutput($sformatf("%s blk%0d", name, i), outLog[i], sentQ[i]);
        end
        sentQ.delete();
        outLog.delete();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t         vecs[6];
        logic [127:0] d;

        vecs[0] = '{128'h1, 0, 128'h0, 128'h1};
        vecs[1] = '{128'h1, 1, 128'h0, 128'h2};
        vecs[2] = '{128'h1, 2, 128'h0, 128'h4};
        vecs[3] = '{128'h1, 3, 128'h0, 128'h8};
        vecs[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 0, 128'h0,
                    128'h8000_0000_0000_0000_0000_0000_0000_0000};
        vecs[5] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 1, 128'h0, 128'h87};

        // Table vectors through a 3-cycle identity core
        coreLat = 3;
        doReset();
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].idx == 0) begin
                if (i > 0) begin
                    drain();
                    checkLoopback("table loopback");
                end
                doReset();
                loadTweak(vecs[i].t0);
            end
            applyStimulus(1'b1, vecs[i].din, 1'b0, '0);
            if (lastHs) sentQ.push_back(vecs[i].din);
            checkOutput($sformatf("vec%0d strobe", i), 128'(o_cipher_valid), 128'd1);
            checkOutput($sformatf("vec%0d cipher", i), o_cipher_data, vecs[i].expCipher);
        end
        drain();
        checkLoopback("table loopback");

        // Full sector, back-to-back, 1-cycle core; the 33rd block must stall
        doReset();
        coreLat = 1;
        loadTweak(rand128());
        for (int i = 0; i < BPS; i++) pendQ.push_back(rand128());
        feedAll();
        d = rand128();
        applyStimulus(1'b1, d, 1'b0, '0);
        applyStimulus(1'b1, d, 1'b0, '0);
        checkOutput("sector end ready pair", {126'b0, o_tweak_ready, o_data_ready}, 128'b10);
        drain();
        checkLoopback("sector loopback");
        loadTweak(rand128());
        pendQ.push_back(d);
        feedAll();
        drain();
        checkLoopback("next sector loopback");

        // 10-cycle core fills the 4-entry FIFO and throttles input
        doReset();
        coreLat = 10;
        loadTweak(rand128());
        for (int i = 0; i < 4; i++) begin
            d = rand128();
            applyStimulus(1'b1, d, 1'b0, '0);
            if (lastHs) sentQ.push_back(d);
        end
        checkOutput("fifo full stall", 128'(o_data_ready), 128'd0);
        for (int i = 0; i < 6; i++) pendQ.push_back(rand128());
        feedAll();
        drain();
        checkLoopback("latency10 loopback");

        // Reset after 5 blocks of a sector, then restart with T0 = 3
        doReset();
        coreLat = 3;
        loadTweak(rand128());
        for (int i = 0; i < 5; i++) pendQ.push_back(rand128());
        feedAll();
        doReset();
        loadTweak(128'h3);
        d = rand128();
        applyStimulus(1'b1, d, 1'b0, '0);
        checkOutput("restart cipher", o_cipher_data, d ^ 128'h3);
        sentQ.push_back(d);
        drain();
        checkLoopback("restart loopback");

        // Core result with nothing queued: dropped, sticky error until reset
        doReset();
        injectCipher = 1'b1;
        injectData   = rand128();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("orphan no valid", 128'(o_data_valid), 128'd0);
        checkOutput("orphan err set", 128'(o_err), 128'd1);
        idleCycles(3);
        checkOutput("orphan err held", 128'(o_err), 128'd1);
        doReset();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
